// File: rtl/hex_display_ctrl_pkg.sv
// Shared types and constants for the dual-digit hex display controller.
package hex_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW_SOC = 2'd1,
        SHOW_DBG = 2'd2,
        ERROR    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_SOC   = 2'd1,
        OWNER_DBG   = 2'd2,
        OWNER_ERROR = 2'd3
    } owner_t;

    localparam logic [7:0] ERROR_CODE = 8'hEE;

    // The owner code reported on the display port is a direct image of the state.
    function automatic owner_t owner_of(input state_t s);
        owner_t o;
        case (s)
            SHOW_SOC: o = OWNER_SOC;
            SHOW_DBG: o = OWNER_DBG;
            ERROR:    o = OWNER_ERROR;
            default:  o = OWNER_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Count 0..TICK_DIV-1 and wrap; the tick is the terminal count itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = !reset && (count == LAST);

endmodule

// File: rtl/hex_display_ctrl.sv
// Arbitrates the SoC and debug byte streams onto one hex display, with a
// minimum ownership hold, round-robin hand-over and a blinking error override.
module hex_display_ctrl
    import hex_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int HOLD_TICKS  = 100,
    parameter int BLINK_TICKS = 25
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_soc_valid,
    input  logic [7:0] i_soc_byte,
    output logic       o_soc_ready,
    input  logic       i_dbg_valid,
    input  logic [7:0] i_dbg_byte,
    output logic       o_dbg_ready,
    input  logic       i_error,
    output logic [7:0] o_byte,
    output logic       o_blank,
    output logic [1:0] o_owner
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    state_t        state;
    state_t        state_next;
    logic          tick;
    logic [7:0]    byte_q;
    logic          blank_q;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] blink_cnt;
    logic          rr_dbg;
    logic          hold_done;
    logic          soc_ready;
    logic          dbg_ready;
    logic          soc_take;
    logic          dbg_take;
    logic          owner_change;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clock(i_clock),
        .reset(i_reset),
        .tick (tick)
    );

    assign hold_done = (hold_cnt == HOLD_MAX);

    // State register; reset overrides everything including a pending error.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready grant, transfer detection and next state; error and reset mask all grants.
    always_comb begin
        state_next   = state;
        soc_ready    = 1'b0;
        dbg_ready    = 1'b0;
        soc_take     = 1'b0;
        dbg_take     = 1'b0;
        owner_change = 1'b0;
        if (!i_reset && !i_error) begin
            case (state)
                IDLE: begin
                    if (rr_dbg) begin
                        if (i_dbg_valid || !i_soc_valid) dbg_ready = 1'b1;
                        else                             soc_ready = 1'b1;
                    end else begin
                        if (i_soc_valid || !i_dbg_valid) soc_ready = 1'b1;
                        else                             dbg_ready = 1'b1;
                    end
                end
                SHOW_SOC: begin
                    if (hold_done && i_dbg_valid) dbg_ready = 1'b1;
                    else                          soc_ready = 1'b1;
                end
                SHOW_DBG: begin
                    if (hold_done && i_soc_valid) soc_ready = 1'b1;
                    else                          dbg_ready = 1'b1;
                end
                default: begin
                end
            endcase
        end
        soc_take     = soc_ready && i_soc_valid;
        dbg_take     = dbg_ready && i_dbg_valid;
        owner_change = (soc_take && state != SHOW_SOC) || (dbg_take && state != SHOW_DBG);
        if (i_error) begin
            state_next = ERROR;
        end else if (state == ERROR) begin
            state_next = IDLE;
        end else if (soc_take) begin
            state_next = SHOW_SOC;
        end else if (dbg_take) begin
            state_next = SHOW_DBG;
        end
    end

    // Displayed byte, blanking, hold/blink counters and round-robin pointer.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            byte_q    <= 8'h00;
            blank_q   <= 1'b1;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            rr_dbg    <= 1'b0;
        end else if (i_error) begin
            byte_q <= ERROR_CODE;
            if (state != ERROR) begin
                blank_q   <= 1'b0;
                blink_cnt <= '0;
            end else if (tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blank_q   <= ~blank_q;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end else if (state == ERROR) begin
            byte_q  <= 8'h00;
            blank_q <= 1'b0;
        end else begin
            if (soc_take) begin
                byte_q  <= i_soc_byte;
                blank_q <= 1'b0;
                rr_dbg  <= 1'b1;
            end else if (dbg_take) begin
                byte_q  <= i_dbg_byte;
                blank_q <= 1'b0;
                rr_dbg  <= 1'b0;
            end
            if (owner_change) begin
                hold_cnt <= '0;
            end else if (tick && !hold_done) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    assign o_soc_ready = soc_ready;
    assign o_dbg_ready = dbg_ready;
    assign o_byte      = byte_q;
    assign o_blank     = blank_q;
    assign o_owner     = owner_of(state);

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl with short tick/hold/blink periods.
module tb_hex_display_ctrl;

    logic       clock;
    logic       reset;
    logic       soc_valid;
    logic [7:0] soc_byte;
    logic       soc_ready;
    logic       dbg_valid;
    logic [7:0] dbg_byte;
    logic       dbg_ready;
    logic       error;
    logic [7:0] disp_byte;
    logic       blank;
    logic [1:0] owner;

    int tests;
    int failures;
    int cyc;

    hex_display_ctrl #(
        .TICK_DIV   (4),
        .HOLD_TICKS (3),
        .BLINK_TICKS(2)
    ) dut (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_soc_valid(soc_valid),
        .i_soc_byte (soc_byte),
        .o_soc_ready(soc_ready),
        .i_dbg_valid(dbg_valid),
        .i_dbg_byte (dbg_byte),
        .o_dbg_ready(dbg_ready),
        .i_error    (error),
        .o_byte     (disp_byte),
        .o_blank    (blank),
        .o_owner    (owner)
    );

    // 10-unit clock period.
    always #5 clock = ~clock;

    task automatic apply_stimulus(input logic rst, input logic sv, input logic [7:0] sb,
                                  input logic dv, input logic [7:0] db, input logic err);
        reset     = rst;
        soc_valid = sv;
        soc_byte  = sb;
        dbg_valid = dv;
        dbg_byte  = db;
        error     = err;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        clock    = 1'b0;
        tests    = 0;
        failures = 0;
        cyc      = 0;

        // Reset with every requester valid: nothing may be granted.
        apply_stimulus(1'b1, 1'b1, 8'h5A, 1'b1, 8'h3C, 1'b0);
        repeat (3) step();
        check_output("reset_byte",      disp_byte, 8'h00);
        check_output("reset_blank",     blank,     8'h01);
        check_output("reset_owner",     owner,     8'h00);
        check_output("reset_soc_ready", soc_ready, 8'h00);
        check_output("reset_dbg_ready", dbg_ready, 8'h00);

        // Release with both valid: SoC preferred first.
        apply_stimulus(1'b0, 1'b1, 8'h5A, 1'b1, 8'h3C, 1'b0);
        cyc = 0;
        check_output("idle_soc_ready", soc_ready, 8'h01);
        check_output("idle_dbg_ready", dbg_ready, 8'h00);
        check_output("idle_blank",     blank,     8'h01);
        step();
        check_output("soc_byte",  disp_byte, 8'h5A);
        check_output("soc_owner", owner,     8'h01);
        check_output("soc_blank", blank,     8'h00);

        // Owner updates every cycle while debug waits out the hold (ticks end cycles 4, 8, 12).
        for (int k = 2; k <= 11; k++) begin
            soc_byte = 8'h60 + 8'(k);
            step();
            check_output("soc_update_byte", disp_byte, 8'h60 + 8'(k));
            check_output("hold_dbg_ready",  dbg_ready, 8'h00);
        end
        step();
        check_output("handover_dbg_ready", dbg_ready, 8'h01);
        check_output("handover_soc_ready", soc_ready, 8'h00);
        check_output("handover_owner",     owner,     8'h01);
        check_output("handover_byte",      disp_byte, 8'h6B);
        step();
        check_output("dbg_owner",        owner,     8'h02);
        check_output("dbg_byte",         disp_byte, 8'h3C);
        check_output("dbg_soc_ready",    soc_ready, 8'h00);
        check_output("dbg_dbg_ready",    dbg_ready, 8'h01);

        // Error for 20 edges; readies masked immediately.
        apply_stimulus(1'b0, 1'b1, 8'h99, 1'b1, 8'h98, 1'b1);
        check_output("err_soc_ready_masked", soc_ready, 8'h00);
        check_output("err_dbg_ready_masked", dbg_ready, 8'h00);
        step();
        check_output("err_byte",      disp_byte, 8'hEE);
        check_output("err_owner",     owner,     8'h03);
        check_output("err_blank",     blank,     8'h00);
        check_output("err_soc_ready", soc_ready, 8'h00);
        for (int k = 15; k <= 33; k++) begin
            step();
            check_output("err_blink", blank, (k >= 20 && k <= 27) ? 8'h01 : 8'h00);
        end
        check_output("err_byte_end",  disp_byte, 8'hEE);
        check_output("err_owner_end", owner,     8'h03);

        // Error drop: back to IDLE with pointer still at SoC.
        apply_stimulus(1'b0, 1'b1, 8'h99, 1'b1, 8'h98, 1'b0);
        check_output("err_last_soc_ready", soc_ready, 8'h00);
        step();
        check_output("exit_owner",     owner,     8'h00);
        check_output("exit_byte",      disp_byte, 8'h00);
        check_output("exit_blank",     blank,     8'h00);
        check_output("exit_soc_ready", soc_ready, 8'h01);
        check_output("exit_dbg_ready", dbg_ready, 8'h00);

        // Error and offered SoC byte together: error wins.
        apply_stimulus(1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
        check_output("race_soc_ready", soc_ready, 8'h00);
        step();
        check_output("race_owner", owner,     8'h03);
        check_output("race_byte",  disp_byte, 8'hEE);
        apply_stimulus(1'b0, 1'b0, 8'h77, 1'b0, 8'h00, 1'b0);
        step();
        check_output("race_exit_byte",  disp_byte, 8'h00);
        check_output("race_exit_owner", owner,     8'h00);

        // Lone debug request is served even when SoC is preferred.
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0);
        check_output("lone_dbg_ready", dbg_ready, 8'h01);
        step();
        check_output("lone_dbg_owner", owner,     8'h02);
        check_output("lone_dbg_byte",  disp_byte, 8'hA5);

        // Reset in SHOW_DBG overrides error and pending transfers.
        apply_stimulus(1'b1, 1'b1, 8'h11, 1'b1, 8'h11, 1'b1);
        check_output("mid_reset_soc_ready", soc_ready, 8'h00);
        check_output("mid_reset_dbg_ready", dbg_ready, 8'h00);
        step();
        check_output("mid_reset_owner", owner,     8'h00);
        check_output("mid_reset_byte",  disp_byte, 8'h00);
        check_output("mid_reset_blank", blank,     8'h01);

        // After SoC ownership the pointer prefers debug.
        apply_stimulus(1'b0, 1'b1, 8'h42, 1'b0, 8'h00, 1'b0);
        step();
        check_output("post_reset_owner", owner,     8'h01);
        check_output("post_reset_byte",  disp_byte, 8'h42);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step();
        apply_stimulus(1'b0, 1'b1, 8'h01, 1'b1, 8'h02, 1'b0);
        check_output("rr_dbg_ready", dbg_ready, 8'h01);
        check_output("rr_soc_ready", soc_ready, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
